payment_sequencer: RTL and testbench

PAYMENT_SEQUENCER -- requirements
Module: payment_sequencer

---
 rtl/payment_sequencer.sv | 158 +++++++++++++++
 tb/tb_payment_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payment_sequencer.sv
// Payment sequencer: collects notes against a price, then pays change coin by coin.
// Optional idle timeout in COLLECT is enabled by defining PAYMENT_TIMEOUT_EN.
module payment_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       startPay,
    input  logic [4:0] valueToPay,
    input  logic       moneyValid,
    input  logic [4:0] inputMoney,
    input  logic       cancel,
    input  logic       dispAck,
    output logic       dispReq,
    output logic [4:0] dispCoin,
    output logic       rejectPulse,
    output logic [5:0] paidTotal,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StCollect  = 3'b001,
        StSelect   = 3'b010,
        StDispense = 3'b011,
        StDone     = 3'b100
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] price_q, price_d;
    logic [5:0] change_q, change_d;
    logic [5:0] paid_q, paid_d;
    logic       req_q, req_d;
    logic [4:0] coin_q, coin_d;
    logic       rej_q, rej_d;
    logic       done_q, done_d;

    logic       note_ok;
    logic [5:0] paid_next;
    logic       timeout;

    assign note_ok = (inputMoney == 5'd10) || (inputMoney == 5'd20) || (inputMoney == 5'd30);

`ifdef PAYMENT_TIMEOUT_EN
    logic [7:0] idle_cnt_q;

    assign timeout = (state_q == StCollect) && (idle_cnt_q == 8'hff);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= 8'd0;
        end else if (state_q == StIdle && startPay) begin
            idle_cnt_q <= 8'd0;
        end else if (state_q == StCollect) begin
            idle_cnt_q <= moneyValid ? 8'd0 : idle_cnt_q + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        price_d   = price_q;
        change_d  = change_q;
        paid_d    = paid_q;
        req_d     = req_q;
        coin_d    = coin_q;
        done_d    = 1'b0;
        paid_next = paid_q;
        // Any note that is not a valid note arriving in COLLECT is handed back.
        rej_d     = moneyValid && !((state_q == StCollect) && note_ok);

        case (state_q)
            StIdle: begin
                if (startPay) begin
                    price_d  = valueToPay;
                    paid_d   = 6'd0;
                    change_d = 6'd0;
                    state_d  = (valueToPay == 5'd0) ? StSelect : StCollect;
                end
            end
            StCollect: begin
                if (moneyValid && note_ok) begin
                    paid_next = paid_q + {1'b0, inputMoney};
                end
                paid_d = paid_next;
                // Abort wins over a reached price, refunding the just-added note too.
                if (cancel || timeout) begin
                    change_d = paid_next;
                    state_d  = StSelect;
                end else if (paid_next >= {1'b0, price_q}) begin
                    change_d = paid_next - {1'b0, price_q};
                    state_d  = StSelect;
                end
            end
            StSelect: begin
                if (change_q == 6'd0) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    req_d   = 1'b1;
                    state_d = StDispense;
                    if (change_q >= 6'd20)      coin_d = 5'd20;
                    else if (change_q >= 6'd10) coin_d = 5'd10;
                    else if (change_q >= 6'd5)  coin_d = 5'd5;
                    else if (change_q >= 6'd2)  coin_d = 5'd2;
                    else                        coin_d = 5'd1;
                end
            end
            StDispense: begin
                if (dispAck) begin
                    change_d = change_q - {1'b0, coin_q};
                    req_d    = 1'b0;
                    coin_d   = 5'd0;
                    state_d  = StSelect;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                req_d   = 1'b0;
                coin_d  = 5'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            price_q  <= 5'd0;
            change_q <= 6'd0;
            paid_q   <= 6'd0;
            req_q    <= 1'b0;
            coin_q   <= 5'd0;
            rej_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            price_q  <= price_d;
            change_q <= change_d;
            paid_q   <= paid_d;
            req_q    <= req_d;
            coin_q   <= coin_d;
            rej_q    <= rej_d;
            done_q   <= done_d;
        end
    end

    assign dispReq     = req_q;
    assign dispCoin    = coin_q;
    assign rejectPulse = rej_q;
    assign paidTotal   = paid_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_payment_sequencer.sv
// Self-checking bench for payment_sequencer: transaction-level reference model with a
// coin queue, directed scenarios with literal expectations, then randomized traffic.
module tb_payment_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       startPay = 1'b0;
    logic [4:0] valueToPay = 5'd0;
    logic       moneyValid = 1'b0;
    logic [4:0] inputMoney = 5'd0;
    logic       cancel = 1'b0;
    logic       dispAck = 1'b0;
    logic       dispReq;
    logic [4:0] dispCoin;
    logic       rejectPulse;
    logic [5:0] paidTotal;
    logic       done;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    payment_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .startPay   (startPay),
        .valueToPay (valueToPay),
        .moneyValid (moneyValid),
        .inputMoney (inputMoney),
        .cancel     (cancel),
        .dispAck    (dispAck),
        .dispReq    (dispReq),
        .dispCoin   (dispCoin),
        .rejectPulse(rejectPulse),
        .paidTotal  (paidTotal),
        .done       (done),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase numbers are the externally visible state codes.
    int m_phase, m_price, m_paid, m_coin, m_cnt;
    bit m_req, m_rej, m_done, m_note_ok, m_abort;
    int m_coins[$];

    function automatic void plan_coins(input int amount);
        int denoms[5];
        int amt;
        denoms = '{20, 10, 5, 2, 1};
        amt = amount;
        m_coins.delete();
        for (int i = 0; i < 5; i++) begin
            while (amt >= denoms[i]) begin
                m_coins.push_back(denoms[i]);
                amt -= denoms[i];
            end
        end
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_price = 0; m_paid = 0; m_coin = 0; m_cnt = 0;
            m_req = 0; m_rej = 0; m_done = 0;
            m_coins.delete();
        end else begin
            m_note_ok = (inputMoney == 10) || (inputMoney == 20) || (inputMoney == 30);
            m_rej  = moneyValid && !(m_phase == 1 && m_note_ok);
            m_done = 0;
            case (m_phase)
                0: if (startPay) begin
                    m_price = valueToPay;
                    m_paid  = 0;
                    m_cnt   = 0;
                    m_coins.delete();
                    m_phase = (valueToPay == 0) ? 2 : 1;
                end
                1: begin
                    m_abort = cancel;
`ifdef PAYMENT_TIMEOUT_EN
                    if (m_cnt == 255) m_abort = 1;
                    m_cnt = moneyValid ? 0 : m_cnt + 1;
`endif
                    if (moneyValid && m_note_ok) m_paid += inputMoney;
                    if (m_abort) begin
                        plan_coins(m_paid);
                        m_phase = 2;
                    end else if (m_paid >= m_price) begin
                        plan_coins(m_paid - m_price);
                        m_phase = 2;
                    end
                end
                2: if (m_coins.size() == 0) begin
                    m_done  = 1;
                    m_phase = 4;
                end else begin
                    m_req   = 1;
                    m_coin  = m_coins[0];
                    m_phase = 3;
                end
                3: if (dispAck) begin
                    void'(m_coins.pop_front());
                    m_req   = 0;
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Compare process: every cycle out of reset, plus a log of coins actually requested.
    int  seen[$];
    int  done_cnt = 0;
    bit  prev_req = 0;

    always @(negedge clock) begin
        if (reset) begin
            check("state", state, m_phase);
            check("dispReq", dispReq, m_req);
            check("rejectPulse", rejectPulse, m_rej);
            check("paidTotal", paidTotal, m_paid);
            check("done", done, m_done);
            if (m_req) check("dispCoin", dispCoin, m_coin);
            if (dispReq && !prev_req) seen.push_back(dispCoin);
            if (done) done_cnt++;
        end
        prev_req = dispReq;
    end

    task automatic step(input bit sp, input int val, input bit mv, input int money,
                        input bit c, input bit ack_rand);
        startPay   = sp;
        valueToPay = val[4:0];
        moneyValid = mv;
        inputMoney = money[4:0];
        cancel     = c;
        dispAck    = ack_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
        @(negedge clock);
    endtask

    task automatic finish_txn(input string name);
        int n = 0;
        while (state != 3'd0 && n < 300) begin
            step(0, 0, 0, 0, 0, 1);
            n++;
        end
        check({name, " reaches idle"}, state, 0);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    int d0;
    int moneys[4];

    initial begin
        moneys = '{10, 20, 30, 0};
        #12;
        check("reset state", state, 0);
        check("reset dispReq", dispReq, 0);
        check("reset paidTotal", paidTotal, 0);
        check("reset done", done, 0);
        @(negedge clock);
        reset = 1'b1;
        idle_steps(2);

        // price 25, three tens -> one 5 coin
        seen.delete(); d0 = done_cnt;
        step(1, 25, 0, 0, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        finish_txn("t25");
        check("t25 paidTotal", paidTotal, 30);
        check("t25 coin count", seen.size(), 1);
        check("t25 coin0", seen[0], 5);
        check("t25 done pulses", done_cnt - d0, 1);

        // price 7, one thirty -> 20, 2, 1
        seen.delete(); d0 = done_cnt;
        step(1, 7, 0, 0, 0, 1);
        step(0, 0, 1, 30, 0, 1);
        finish_txn("t7");
        check("t7 coin count", seen.size(), 3);
        check("t7 coin0", seen[0], 20);
        check("t7 coin1", seen[1], 2);
        check("t7 coin2", seen[2], 1);
        check("t7 done pulses", done_cnt - d0, 1);

        // invalid note 15 is rejected one cycle later and not counted
        seen.delete();
        step(1, 20, 0, 0, 0, 1);
        step(0, 0, 1, 15, 0, 1);
        check("t15 rejectPulse", rejectPulse, 1);
        check("t15 paidTotal", paidTotal, 0);
        check("t15 state", state, 1);
        step(0, 0, 0, 0, 0, 1);
        check("t15 reject one cycle", rejectPulse, 0);
        step(0, 0, 0, 0, 1, 1);
        finish_txn("t15");
        check("t15 coin count", seen.size(), 0);

        // cancel together with the price-reaching note refunds everything
        seen.delete();
        step(1, 20, 0, 0, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        step(0, 0, 1, 10, 1, 1);
        finish_txn("tcancel");
        check("tcancel paidTotal", paidTotal, 20);
        check("tcancel coin count", seen.size(), 1);
        check("tcancel coin0", seen[0], 20);

        // price 0 goes straight to done with no coins
        seen.delete(); d0 = done_cnt;
        step(1, 0, 0, 0, 0, 1);
        finish_txn("tzero");
        check("tzero coin count", seen.size(), 0);
        check("tzero done pulses", done_cnt - d0, 1);

        // reset while a coin request is pending
        step(1, 7, 0, 0, 0, 0);
        step(0, 0, 1, 30, 0, 0);
        for (int i = 0; i < 10 && !dispReq; i++) step(0, 0, 0, 0, 0, 0);
        check("trst dispReq before reset", dispReq, 1);
        #2 reset = 1'b0;
        #1;
        check("trst state", state, 0);
        check("trst dispReq", dispReq, 0);
        check("trst dispCoin", dispCoin, 0);
        check("trst paidTotal", paidTotal, 0);
        check("trst done", done, 0);
        check("trst rejectPulse", rejectPulse, 0);
        @(negedge clock);
        reset = 1'b1;
        idle_steps(2);
        check("trst still idle", state, 0);
        seen.delete();
        step(1, 25, 0, 0, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        step(0, 0, 1, 20, 0, 1);
        finish_txn("trst after");
        check("trst after coin count", seen.size(), 1);
        check("trst after coin0", seen[0], 5);

`ifdef PAYMENT_TIMEOUT_EN
        seen.delete();
        step(1, 20, 0, 0, 0, 1);
        step(0, 0, 1, 10, 0, 1);
        for (int i = 0; i < 300 && state == 3'd1; i++) step(0, 0, 0, 0, 0, 0);
        finish_txn("ttimeout");
        check("ttimeout coin count", seen.size(), 1);
        check("ttimeout coin0", seen[0], 10);
`endif

        // randomized traffic, including stray notes, acks and starts
        for (int i = 0; i < 3000; i++) begin
            int val;
            int money;
            val   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 31);
            money = moneys[$urandom_range(0, 3)];
            if (money == 0) money = $urandom_range(0, 31);
            step($urandom_range(0, 7) == 0, val, $urandom_range(0, 3) == 0, money,
                 $urandom_range(0, 24) == 0, 1);
        end
        finish_txn("random tail");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
